zbt_port_arbiter: RTL and testbench

// - Single-port ZBT access arbiter between the NTSC capture path and the VGA display fetch.
// - Upstream: ntsc_to_zbt write stream (addr/data/we). Downstream: ZBT SRAM pins and display pixel logic.
// - Display reads win every cycle they are requested and have fixed latency.
// - NTSC writes are buffered in a small FIFO and issued on idle cycles; overflow drops and flags.

---
 rtl/zbt_port_arbiter_pkg.sv | 22 ++
 rtl/zbt_port_arbiter_wr_fifo.sv | 58 +++++
 rtl/zbt_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_zbt_port_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/zbt_port_arbiter_pkg.sv
// rtl/zbt_port_arbiter_pkg.sv - shared constants and types for the ZBT port arbiter
package zbt_port_arbiter_pkg;

  // ZBT pipeline depths, counted from the cycle an access is visible on the pins
  localparam int ZBT_RD_LAT = 2;
  localparam int ZBT_WR_LAT = 2;

  // disp_req to disp_valid: issue register + ZBT read pipe + capture register
  localparam int DISP_LAT = ZBT_RD_LAT + 2;

  localparam int ADDR_W_DEF     = 19;
  localparam int DATA_W_DEF     = 36;
  localparam int FIFO_DEPTH_DEF = 4;

  // What the single ZBT port does in a given cycle
  typedef enum logic [1:0] {
    ISSUE_IDLE  = 2'd0,
    ISSUE_READ  = 2'd1,
    ISSUE_WRITE = 2'd2
  } issue_e;

endpackage

// File: rtl/zbt_port_arbiter_wr_fifo.sv
// rtl/zbt_port_arbiter_wr_fifo.sv - write FIFO holding {addr,data} for NTSC capture writes
module zbt_wr_fifo #(
  parameter int WIDTH = 55,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_LVL = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (level == FULL_LVL);
  assign empty    = (level == '0);
  assign pop_data = mem[rd_ptr];

  // A push into a full FIFO is only accepted when the head leaves in the same cycle
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage needs no reset: the pointers and level define which entries are live
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/zbt_port_arbiter.sv
// rtl/zbt_port_arbiter.sv - single-port ZBT arbiter: display reads first, buffered NTSC writes on idle cycles
module zbt_port_arbiter
  import zbt_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ntsc_we,
  input  logic [ADDR_W-1:0]             ntsc_addr,
  input  logic [DATA_W-1:0]             ntsc_data,
  input  logic                          disp_req,
  input  logic [ADDR_W-1:0]             disp_addr,
  output logic                          disp_valid,
  output logic [DATA_W-1:0]             disp_data,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic                          mem_we_n,
  output logic [DATA_W-1:0]             mem_dout,
  output logic                          mem_oe,
  input  logic [DATA_W-1:0]             mem_din,
  output logic                          wr_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int ENTRY_W = ADDR_W + DATA_W;
  localparam int RD_N    = DISP_LAT - 1;

  logic               we_d1;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  logic [ENTRY_W-1:0] fifo_head;
  logic [ADDR_W-1:0]  head_addr;
  logic [DATA_W-1:0]  head_data;
  issue_e             issue_sel;

  logic [ZBT_WR_LAT-1:0] wr_vld;
  logic [DATA_W-1:0]     wr_dat [ZBT_WR_LAT];
  logic [RD_N-1:0]       rd_vld;

  // The capture stage presents addr/data one cycle after its we pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_d1 <= 1'b0;
    end else begin
      we_d1 <= ntsc_we;
    end
  end

  zbt_wr_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (we_d1),
    .push_data ({ntsc_addr, ntsc_data}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign head_addr = fifo_head[ENTRY_W-1:DATA_W];
  assign head_data = fifo_head[DATA_W-1:0];

  // Priority issue: a display read always wins, otherwise drain one buffered write
  always_comb begin
    issue_sel = ISSUE_IDLE;
    fifo_pop  = 1'b0;
    if (disp_req) begin
      issue_sel = ISSUE_READ;
    end else if (!fifo_empty) begin
      issue_sel = ISSUE_WRITE;
      fifo_pop  = 1'b1;
    end
  end

  // Registered ZBT address/control; idle cycles keep the last address on the pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr <= '0;
      mem_we_n <= 1'b1;
    end else begin
      case (issue_sel)
        ISSUE_READ: begin
          mem_addr <= disp_addr;
          mem_we_n <= 1'b1;
        end
        ISSUE_WRITE: begin
          mem_addr <= head_addr;
          mem_we_n <= 1'b0;
        end
        default: begin
          mem_we_n <= 1'b1;
        end
      endcase
    end
  end

  // Write data follows its address by the ZBT write latency before it is driven
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_vld <= '0;
      for (int i = 0; i < ZBT_WR_LAT; i++) wr_dat[i] <= '0;
      mem_oe   <= 1'b0;
      mem_dout <= '0;
    end else begin
      wr_vld[0] <= (issue_sel == ISSUE_WRITE);
      wr_dat[0] <= head_data;
      for (int i = 1; i < ZBT_WR_LAT; i++) begin
        wr_vld[i] <= wr_vld[i-1];
        wr_dat[i] <= wr_dat[i-1];
      end
      mem_oe <= wr_vld[ZBT_WR_LAT-1];
      if (wr_vld[ZBT_WR_LAT-1]) begin
        mem_dout <= wr_dat[ZBT_WR_LAT-1];
      end
    end
  end

  // Read-valid delay line: capture mem_din when the issued read's data is on the pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld     <= '0;
      disp_valid <= 1'b0;
      disp_data  <= '0;
    end else begin
      rd_vld     <= {rd_vld[RD_N-2:0], (issue_sel == ISSUE_READ)};
      disp_valid <= rd_vld[RD_N-1];
      if (rd_vld[RD_N-1]) begin
        disp_data <= mem_din;
      end
    end
  end

  // Sticky drop flag: a push arrived while full and nothing left the FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_overflow <= 1'b0;
    end else if (we_d1 && fifo_full && !fifo_pop) begin
      wr_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_zbt_port_arbiter.sv
// tb/tb_zbt_port_arbiter.sv - scoreboard bench for zbt_port_arbiter
`timescale 1ns/1ps
module tb_zbt_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ntsc_we;
  logic [18:0] ntsc_addr;
  logic [35:0] ntsc_data;
  logic        disp_req;
  logic [18:0] disp_addr;
  logic        disp_valid;
  logic [35:0] disp_data;
  logic [18:0] mem_addr;
  logic        mem_we_n;
  logic [35:0] mem_dout;
  logic        mem_oe;
  logic [35:0] mem_din;
  logic        wr_overflow;
  logic [2:0]  fifo_level;

  zbt_port_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ntsc_we     (ntsc_we),
    .ntsc_addr   (ntsc_addr),
    .ntsc_data   (ntsc_data),
    .disp_req    (disp_req),
    .disp_addr   (disp_addr),
    .disp_valid  (disp_valid),
    .disp_data   (disp_data),
    .mem_addr    (mem_addr),
    .mem_we_n    (mem_we_n),
    .mem_dout    (mem_dout),
    .mem_oe      (mem_oe),
    .mem_din     (mem_din),
    .wr_overflow (wr_overflow),
    .fifo_level  (fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct { logic [18:0] addr; logic [35:0] data; } wr_t;
  typedef struct { int unsigned cyc; logic [35:0] data; } ev_t;

  wr_t wq[$];
  ev_t oq[$];
  ev_t rdq[$];

  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned cyc     = 0;
  int          n_we_seen    = 0;
  int          n_valid_seen = 0;
  logic [18:0] a0 = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [35:0] data_for(input logic [18:0] a);
    return 36'hABCDE + 36'(a) * 36'h111 - 36'h2220;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // ZBT model: address on the pins in cycle c returns data during cycle c+2
  always @(posedge clk) begin
    mem_din <= data_for(a0);
    a0      <= mem_addr;
  end

  // Monitor: compare every write issue, write-data drive and read return
  always @(negedge clk) begin
    if (rst_n) begin
      if (!mem_we_n) begin
        n_we_seen++;
        if (wq.size() == 0) begin
          check("wr_spurious", {63'h0, mem_we_n}, 64'h1);
        end else begin
          wr_t w;
          w = wq.pop_front();
          check("wr_addr", {45'h0, mem_addr}, {45'h0, w.addr});
          oq.push_back('{cyc + 2, w.data});
        end
      end
      if (mem_oe) begin
        if (oq.size() == 0) begin
          check("oe_spurious", {63'h0, mem_oe}, 64'h0);
        end else begin
          ev_t e;
          e = oq.pop_front();
          check("oe_cycle", 64'(cyc), 64'(e.cyc));
          check("oe_data", {28'h0, mem_dout}, {28'h0, e.data});
        end
      end
      if (disp_valid) begin
        n_valid_seen++;
        if (rdq.size() == 0) begin
          check("rd_spurious", {63'h0, disp_valid}, 64'h0);
        end else begin
          ev_t e;
          e = rdq.pop_front();
          check("rd_cycle", 64'(cyc), 64'(e.cyc));
          check("rd_data", {28'h0, disp_data}, {28'h0, e.data});
        end
      end
    end
  end

  // One cycle of stimulus: record a read expectation for this cycle, then advance
  task automatic tick();
    if (disp_req && rst_n) rdq.push_back('{cyc + 4, data_for(disp_addr)});
    @(negedge clk);
    if (disp_req) disp_addr = disp_addr + 1'b1;
  endtask

  task automatic write(input logic [18:0] a, input logic [35:0] d, input bit keep, input bit release_req);
    ntsc_we = 1'b1;
    tick();
    ntsc_we   = 1'b0;
    ntsc_addr = a;
    ntsc_data = d;
    if (release_req) disp_req = 1'b0;
    if (keep) wq.push_back('{a, d});
    tick();
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((wq.size() + oq.size() + rdq.size()) != 0 && n < 60) begin
      tick();
      n++;
    end
    check(tag, 64'(wq.size() + oq.size() + rdq.size()), 64'h0);
    repeat (3) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"},  {45'h0, mem_addr}, 64'h0);
    check({tag, "_we_n"},  {63'h0, mem_we_n}, 64'h1);
    check({tag, "_oe"},    {63'h0, mem_oe}, 64'h0);
    check({tag, "_dout"},  {28'h0, mem_dout}, 64'h0);
    check({tag, "_valid"}, {63'h0, disp_valid}, 64'h0);
    check({tag, "_data"},  {28'h0, disp_data}, 64'h0);
    check({tag, "_ovf"},   {63'h0, wr_overflow}, 64'h0);
    check({tag, "_level"}, {61'h0, fifo_level}, 64'h0);
  endtask

  initial begin
    int we_before;
    int v_before;
    rst_n = 1'b0;
    ntsc_we = 1'b0; ntsc_addr = '0; ntsc_data = '0;
    disp_req = 1'b0; disp_addr = '0;
    repeat (3) @(negedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) tick();

    // Single write: issue three cycles after the pulse, data driven two after that
    write(19'h00010, 36'h123456789, 1'b1, 1'b0);
    check("sw_level", {61'h0, fifo_level}, 64'h1);
    check("sw_we_early", {63'h0, mem_we_n}, 64'h1);
    tick();
    check("sw_we", {63'h0, mem_we_n}, 64'h0);
    check("sw_addr", {45'h0, mem_addr}, 64'h10);
    tick();
    check("sw_oe_early", {63'h0, mem_oe}, 64'h0);
    tick();
    check("sw_oe", {63'h0, mem_oe}, 64'h1);
    check("sw_dout", {28'h0, mem_dout}, 64'h123456789);
    drain("sw_drain");

    // Read latency of exactly four
    disp_addr = 19'h00020;
    disp_req  = 1'b1;
    tick();
    disp_req  = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      check($sformatf("rl_valid_%0d", i), {63'h0, disp_valid}, (i == 4) ? 64'h1 : 64'h0);
      if (i == 4) check("rl_data", {28'h0, disp_data}, 64'hABCDE);
      tick();
    end
    drain("rl_drain");

    // Back-to-back reads
    disp_addr = 19'h00100;
    disp_req  = 1'b1;
    repeat (6) tick();
    disp_req  = 1'b0;
    drain("b2b_drain");

    // Reads starve writes; writes then issue on consecutive cycles
    we_before = n_we_seen;
    disp_addr = 19'h00200;
    disp_req  = 1'b1;
    tick();
    write(19'h00301, 36'h111111111, 1'b1, 1'b0);
    write(19'h00302, 36'h222222222, 1'b1, 1'b0);
    write(19'h00303, 36'h333333333, 1'b1, 1'b0);
    repeat (3) tick();
    check("pri_level", {61'h0, fifo_level}, 64'h3);
    check("pri_no_wr", 64'(n_we_seen - we_before), 64'h0);
    disp_req = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("pri_we_%0d", i), {63'h0, mem_we_n}, 64'h0);
      check($sformatf("pri_lvl_%0d", i), {61'h0, fifo_level}, 64'(3 - i));
    end
    drain("pri_drain");

    // Full FIFO with push and pop in the same cycle
    disp_addr = 19'h00400;
    disp_req  = 1'b1;
    for (int i = 0; i < 4; i++) write(19'h00500 + 19'(i), 36'hA00000000 + 36'(i), 1'b1, 1'b0);
    check("fpp_full", {61'h0, fifo_level}, 64'h4);
    write(19'h00504, 36'hA00000004, 1'b1, 1'b1);
    check("fpp_level", {61'h0, fifo_level}, 64'h4);
    check("fpp_ovf", {63'h0, wr_overflow}, 64'h0);
    drain("fpp_drain");

    // Overflow: fifth write dropped, flag sticky
    disp_addr = 19'h00600;
    disp_req  = 1'b1;
    for (int i = 0; i < 4; i++) write(19'h00700 + 19'(i), 36'hB00000000 + 36'(i), 1'b1, 1'b0);
    check("ovf_pre", {63'h0, wr_overflow}, 64'h0);
    write(19'h00704, 36'hB00000004, 1'b0, 1'b0);
    check("ovf_flag", {63'h0, wr_overflow}, 64'h1);
    check("ovf_level", {61'h0, fifo_level}, 64'h4);
    repeat (2) tick();
    disp_req = 1'b0;
    drain("ovf_drain");
    check("ovf_sticky", {63'h0, wr_overflow}, 64'h1);
    check("ovf_empty", {61'h0, fifo_level}, 64'h0);

    // Reset mid-operation: reads in flight, two writes queued
    disp_addr = 19'h00800;
    disp_req  = 1'b1;
    write(19'h00900, 36'hC00000000, 1'b0, 1'b0);
    write(19'h00901, 36'hC00000001, 1'b0, 1'b0);
    check("rst_pre_level", {61'h0, fifo_level}, 64'h2);
    tick();
    disp_req = 1'b0;
    #2;
    rdq.delete(); wq.delete(); oq.delete();
    rst_n = 1'b0;
    #1 check_reset_outputs("rst_mid");
    we_before = n_we_seen;
    v_before  = n_valid_seen;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) tick();
    check("rst_no_wr", 64'(n_we_seen - we_before), 64'h0);
    check("rst_no_valid", 64'(n_valid_seen - v_before), 64'h0);
    check("rst_level", {61'h0, fifo_level}, 64'h0);

    check("end_queues", 64'(wq.size() + oq.size() + rdq.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
